ps2_digit_tx: RTL and testbench

PS2_DIGIT_TX -- requirements
Module: ps2_digit_tx

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_frame_ser.sv | 97 +++++++++
 rtl/ps2_digit_tx.sv | 137 +++++++++++++
 tb/tb_ps2_digit_tx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 digit transmitter.
//   ps2_state_e : controller states (IDLE, FRAME, GAP)
//   FRAME_BITS  : bits per PS/2 frame (start, 8 data, parity, stop)
//   BREAK_CODE  : set-2 break prefix
//   SCAN_TAB    : set-2 make codes for decimal digits 0..9 (index = digit)
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    GAP   = 2'd2
  } ps2_state_e;

  localparam int FRAME_BITS = 11;

  localparam logic [7:0] BREAK_CODE = 8'hF0;

  localparam logic [9:0][7:0] SCAN_TAB = {
    8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E,
    8'h25, 8'h26, 8'h1E, 8'h16, 8'h45
  };

endpackage

// File: rtl/ps2_frame_ser.sv
// Serializes one 11-bit PS/2 frame: start 0, tx_byte LSB first, odd parity,
// stop 1. Each bit lasts 2*CLK_DIV cycles; ps2_clk is high for the first
// CLK_DIV cycles of a bit and low for the last CLK_DIV cycles.
// Ports:
//   clk, areset : system clock, asynchronous active-high reset
//   start       : begin a frame; the start bit is driven on the next cycle
//   tx_byte     : byte to send; must stay stable while the frame is active
//   done        : high on the last cycle of the stop bit
//   ps2_clk     : PS/2 clock line (high when idle)
//   ps2_data    : PS/2 data line (high when idle)
module ps2_frame_ser
  import ps2_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       areset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic       done,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic          active_q, active_d;
  logic          phase_q, phase_d;   // 0: clock-high half, 1: clock-low half
  logic [HW-1:0] half_q, half_d;
  logic [3:0]    bit_q, bit_d;
  logic          half_last;
  logic          last_bit;
  logic [3:0]    data_idx;

  assign half_last = (half_q == HW'(CLK_DIV - 1));
  assign last_bit  = (bit_q == 4'(FRAME_BITS - 1));
  assign data_idx  = bit_q - 4'd1;

  always_comb begin
    active_d = active_q;
    phase_d  = phase_q;
    half_d   = half_q;
    bit_d    = bit_q;
    if (start) begin
      active_d = 1'b1;
      phase_d  = 1'b0;
      half_d   = '0;
      bit_d    = '0;
    end else if (active_q) begin
      if (half_last) begin
        half_d  = '0;
        phase_d = ~phase_q;
        // A bit ends at the close of its clock-low half.
        if (phase_q) begin
          if (last_bit) begin
            active_d = 1'b0;
            bit_d    = '0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end else begin
        half_d = half_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      active_q <= 1'b0;
      phase_q  <= 1'b0;
      half_q   <= '0;
      bit_q    <= '0;
    end else begin
      active_q <= active_d;
      phase_q  <= phase_d;
      half_q   <= half_d;
      bit_q    <= bit_d;
    end
  end

  assign done    = active_q & phase_q & half_last & last_bit;
  assign ps2_clk = ~(active_q & phase_q);

  always_comb begin
    ps2_data = 1'b1;
    if (active_q) begin
      case (bit_q)
        4'd0:    ps2_data = 1'b0;
        4'd9:    ps2_data = ~^tx_byte;   // odd parity over the data byte
        4'd10:   ps2_data = 1'b1;
        default: ps2_data = tx_byte[data_idx[2:0]];
      endcase
    end
  end

endmodule

// File: rtl/ps2_digit_tx.sv
// PS/2 keyboard-style transmitter for decimal digits. An accepted digit is
// looked up (registered) in the set-2 make-code table and sent as PS/2
// frames, each followed by GAP_CYC idle cycles with both lines high.
// Default build sends the make frame only. Defining PS2_DIGIT_TX_BREAK_EN
// sends make, F0, make.
// Ports:
//   clk, areset : system clock, asynchronous active-high reset
//   digit       : digit to send (0..9 legal)
//   digit_valid : request; digit accepted when digit_valid && digit_ready
//   digit_ready : idle and able to accept a digit
//   err         : one-cycle pulse after an illegal digit (10..15) is offered
//   ps2_clk     : PS/2 clock line, idle high
//   ps2_data    : PS/2 data line, idle high
//   busy        : inverse of digit_ready
module ps2_digit_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 8
) (
  input  logic       clk,
  input  logic       areset,
  input  logic [3:0] digit,
  input  logic       digit_valid,
  output logic       digit_ready,
  output logic       err,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy
);

  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

`ifdef PS2_DIGIT_TX_BREAK_EN
  localparam logic [1:0] LAST_FRAME = 2'd2;
`else
  localparam logic [1:0] LAST_FRAME = 2'd0;
`endif

  ps2_state_e    state_q, state_d;
  logic [1:0]    frame_idx_q, frame_idx_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]    code_q, code_d;
  logic          err_q, err_d;
  logic          ser_start;
  logic          ser_done;
  logic [7:0]    tx_byte;

  always_comb begin
    state_d     = state_q;
    frame_idx_d = frame_idx_q;
    gap_cnt_d   = gap_cnt_q;
    code_d      = code_q;
    err_d       = 1'b0;
    ser_start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (digit_valid) begin
          if (digit <= 4'd9) begin
            code_d      = SCAN_TAB[digit];
            frame_idx_d = 2'd0;
            ser_start   = 1'b1;
            state_d     = FRAME;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FRAME: begin
        if (ser_done) begin
          gap_cnt_d = '0;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == GW'(GAP_CYC - 1)) begin
          gap_cnt_d = '0;
          if (frame_idx_q != LAST_FRAME) begin
            frame_idx_d = frame_idx_q + 2'd1;
            ser_start   = 1'b1;
            state_d     = FRAME;
          end else begin
            frame_idx_d = 2'd0;
            state_d     = IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      frame_idx_q <= 2'd0;
      gap_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_idx_q <= frame_idx_d;
      gap_cnt_q   <= gap_cnt_d;
      err_q       <= err_d;
    end
  end

  // Make code is data only; its value is irrelevant while idle.
  always_ff @(posedge clk) begin
    code_q <= code_d;
  end

  // The serializer reads tx_byte live, so the byte for the first frame comes
  // from code_q which is loaded on the same edge that starts the frame.
`ifdef PS2_DIGIT_TX_BREAK_EN
  assign tx_byte = (frame_idx_q == 2'd1) ? BREAK_CODE : code_q;
`else
  assign tx_byte = code_q;
`endif

  ps2_frame_ser #(
    .CLK_DIV (CLK_DIV)
  ) u_ser (
    .clk      (clk),
    .areset   (areset),
    .start    (ser_start),
    .tx_byte  (tx_byte),
    .done     (ser_done),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data)
  );

  assign digit_ready = (state_q == IDLE);
  assign busy        = ~digit_ready;
  assign err         = err_q;

endmodule

// File: tb/tb_ps2_digit_tx.sv
module tb_ps2_digit_tx;

  localparam int CLK_DIV   = 4;
  localparam int GAP_CYC   = 8;
  localparam int FRAME_CYC = 22 * CLK_DIV + GAP_CYC;
`ifdef PS2_DIGIT_TX_BREAK_EN
  localparam int NFR = 3;
`else
  localparam int NFR = 1;
`endif
  localparam int EXP_LOW = (NFR == 3) ? 288 : 96;
  localparam int RST_FR  = (NFR == 3) ? 1 : 0;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic [3:0] digit = 4'd0;
  logic       digit_valid = 1'b0;
  logic       digit_ready, err, ps2_clk, ps2_data, busy;

  ps2_digit_tx #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)) dut (
    .clk         (clk),
    .areset      (areset),
    .digit       (digit),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .err         (err),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [7:0] scan [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                            8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [1:0] mq[$];   // expected {ps2_clk, ps2_data} for upcoming busy cycles
  logic       err_exp = 1'b0;

  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic push_frame(input logic [7:0] b);
    logic [10:0] fb;
    fb = frame_bits(b);
    for (int i = 0; i < 11; i++)
      for (int c = 0; c < 2 * CLK_DIV; c++)
        mq.push_back({(c < CLK_DIV) ? 1'b1 : 1'b0, fb[i]});
    for (int g = 0; g < GAP_CYC; g++) mq.push_back(2'b11);
  endtask

  initial begin : model
    bit was_ready;
    forever begin
      @(posedge clk or posedge areset);
      if (areset) begin
        mq.delete();
        err_exp = 1'b0;
      end else begin
        was_ready = (mq.size() == 0);
        if (!was_ready) void'(mq.pop_front());
        err_exp = 1'b0;
        if (was_ready && digit_valid) begin
          if (digit > 4'd9) err_exp = 1'b1;
          else
            for (int f = 0; f < NFR; f++)
              push_frame((f == 1) ? 8'hF0 : scan[int'(digit)]);
        end
      end
    end
  end

  initial begin : compare
    logic [1:0] e;
    logic       er;
    forever begin
      @(negedge clk);
      er = (mq.size() == 0);
      e  = er ? 2'b11 : mq[0];
      check("digit_ready", int'(digit_ready), int'(er));
      check("busy", int'(busy), int'(!er));
      check("err", int'(err), int'(err_exp));
      check("ps2_clk", int'(ps2_clk), int'(e[1]));
      check("ps2_data", int'(ps2_data), int'(e[0]));
    end
  end

  // ---------------- monitors for literal checks ----------------
  int         low_cnt = 0, err_cnt = 0, line_low_cnt = 0;
  logic       cap_q[$];
  logic [2:0] log_q[$];
  logic       prev_clk = 1'b1;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!digit_ready) low_cnt++;
      if (err) err_cnt++;
      if (!ps2_clk || !ps2_data) line_low_cnt++;
      if (prev_clk && !ps2_clk) cap_q.push_back(ps2_data);
      prev_clk = ps2_clk;
      log_q.push_back({digit_ready, ps2_clk, ps2_data});
    end
  end

  task automatic clear_mon();
    low_cnt = 0; err_cnt = 0; line_low_cnt = 0;
    cap_q.delete(); log_q.delete();
  endtask

  function automatic int cap_frame(input int k);
    logic [10:0] r;
    r = '0;
    for (int i = 0; i < 11; i++)
      if (11 * k + i < cap_q.size()) r[i] = cap_q[11 * k + i];
    return int'(r);
  endfunction

  task automatic send(input logic [3:0] d);
    int n;
    n = 0;
    while (!digit_ready && n < 4000) begin @(negedge clk); n++; end
    check("send_ready_wait", int'(n < 4000), 1);
    digit = d; digit_valid = 1'b1;
    @(negedge clk);
    digit_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!digit_ready && n < 4000) begin @(negedge clk); n++; end
    check("idle_wait", int'(n < 4000), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int s, f, r, t, lo, n;
    bit seen_busy;
    repeat (2) @(negedge clk);
    check("rst_ready", int'(digit_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err), 0);
    check("rst_ps2_clk", int'(ps2_clk), 1);
    check("rst_ps2_data", int'(ps2_data), 1);
    areset = 1'b0;
    repeat (3) @(negedge clk);

    // pin the model's frame builder to hand-derived bit sequences
    check("model_26", int'(frame_bits(8'h26)), int'(11'b10001001100));
    check("model_F0", int'(frame_bits(8'hF0)), int'(11'b11111100000));
    check("model_45", int'(frame_bits(8'h45)), int'(11'b10010001010));

    // digit 3
    clear_mon(); send(4'd3); wait_idle();
    check("d3_ready_low", low_cnt, EXP_LOW);
    check("d3_nbits", cap_q.size(), 11 * NFR);
    check("d3_frame0", cap_frame(0), int'(11'b10001001100));
`ifdef PS2_DIGIT_TX_BREAK_EN
    check("d3_frame1", cap_frame(1), int'(11'b11111100000));
    check("d3_frame2", cap_frame(2), int'(11'b10001001100));
`endif

    // digit 5
    clear_mon(); send(4'd5); wait_idle();
    check("d5_frame0", cap_frame(0), int'(11'b11001011100));
    check("d5_ready_low", low_cnt, EXP_LOW);

    // digit 0 and bit timing
    clear_mon(); send(4'd0); wait_idle();
    check("d0_frame0", cap_frame(0), int'(11'b10010001010));
    s = -1; f = -1;
    for (int i = 0; i < log_q.size(); i++) begin
      if (s < 0 && !log_q[i][0]) s = i;
      if (f < 0 && !log_q[i][1]) f = i;
    end
    check("d0_clk_fall_delay", f - s, 4);
    lo = 0;
    if (f >= 0)
      for (int i = f; i < log_q.size() && !log_q[i][1]; i++) lo++;
    check("d0_low_phase", lo, 4);

    // illegal digit
    clear_mon(); send(4'd10); repeat (20) @(negedge clk);
    check("ill_err_cycles", err_cnt, 1);
    check("ill_ready_low", low_cnt, 0);
    check("ill_line_low", line_low_cnt, 0);

    // reset in the middle of bit 5
    clear_mon(); send(4'd4);
    repeat (RST_FR * FRAME_CYC + 5 * 2 * CLK_DIV + 2) @(negedge clk);
    check("mid_busy", int'(digit_ready), 0);
    #2 areset = 1'b1;
    @(negedge clk);
    check("mid_rst_clk", int'(ps2_clk), 1);
    check("mid_rst_data", int'(ps2_data), 1);
    check("mid_rst_ready", int'(digit_ready), 1);
    @(negedge clk);
    areset = 1'b0;
    clear_mon();
    repeat (300) @(negedge clk);
    check("post_rst_line_low", line_low_cnt, 0);
    check("post_rst_ready_low", low_cnt, 0);

    // back-to-back 7 then 9 with valid held
    clear_mon();
    digit = 4'd7; digit_valid = 1'b1;
    @(negedge clk);
    digit = 4'd9;
    n = 0;
    while (!digit_ready && n < 4000) begin @(negedge clk); n++; end
    while (digit_ready && n < 4000) begin @(negedge clk); n++; end
    check("b2b_wait", int'(n < 4000), 1);
    digit_valid = 1'b0;
    wait_idle();
    check("b2b_code0", (cap_frame(0) >> 1) & 8'hFF, 8'h3D);
    check("b2b_code1", (cap_frame(NFR) >> 1) & 8'hFF, 8'h46);
    r = -1; t = -1; seen_busy = 1'b0;
    for (int i = 0; i < log_q.size(); i++) begin
      if (!log_q[i][2]) seen_busy = 1'b1;
      else if (seen_busy && r < 0) r = i;
    end
    if (r >= 0)
      for (int i = r; i < log_q.size(); i++)
        if (t < 0 && !log_q[i][0]) t = i;
    check("b2b_restart_gap", t - r, 1);

    // randomized traffic, with rare reset pulses
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      digit_valid = ($urandom_range(0, 3) == 0);
      digit       = 4'($urandom_range(0, 15));
      areset      = ($urandom_range(0, 1499) == 0);
    end
    @(negedge clk);
    areset = 1'b0; digit_valid = 1'b0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
